// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and access-size helpers for the load/store unit.
package lsu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} lsu_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  function automatic logic [1:0] size_log2(input logic [2:0] f3);
    return f3[1:0];
  endfunction
  function automatic logic misaligned(input logic [2:0] lo, input logic [2:0] f3);
    return ({1'b0, lo} & ((4'd1 << size_log2(f3)) - 4'd1)) != 4'd0;
  endfunction
  function automatic logic [63:0] byte_mask(input logic [2:0] f3);
    return f3[1:0] == F3_B[1:0] ? 64'h0000_0000_0000_00ff :
           f3[1:0] == F3_H[1:0] ? 64'h0000_0000_0000_ffff :
           f3[1:0] == F3_W[1:0] ? 64'h0000_0000_ffff_ffff : '1;
  endfunction
  function automatic logic is_unsigned(input logic [2:0] f3);
    return f3 == F3_BU || f3 == F3_HU || f3 == F3_WU;
  endfunction
  function automatic logic is_dword(input logic [2:0] f3);
    return f3 == F3_D;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load byte extraction with sign/zero extension, and sub-doubleword store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] word_i,
  input  logic [2:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] ld_data_o,
  output logic [63:0] st_word_o
);
  logic [5:0]  sh;
  logic [63:0] shifted, mask;
  logic        sx;
  always_comb begin
    sh        = {off_i, 3'b000};
    shifted   = word_i >> sh;
    sx        = ~is_unsigned(funct3_i);
    ld_data_o = size_log2(funct3_i) == 2'd0 ? {{56{sx & shifted[7]}}, shifted[7:0]} :
                size_log2(funct3_i) == 2'd1 ? {{48{sx & shifted[15]}}, shifted[15:0]} :
                size_log2(funct3_i) == 2'd2 ? {{32{sx & shifted[31]}}, shifted[31:0]} : shifted;
    mask      = byte_mask(funct3_i) << sh;
    st_word_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV64 load/store FSM over a word-addressed memory without byte enables.
// Define LSU_STATS_EN to add saturating load/store/error counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 32,
  parameter int XLEN       = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_wr_data,
  input  logic [XLEN-1:0] mem_rd_data
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]     stat_loads,
  output logic [31:0]     stat_stores,
  output logic [31:0]     stat_errs
`endif
);
  lsu_state_e      state_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]      f3_q;
  logic            st_q, err_q, bad, active;
  logic [63:0]     ld_data, st_word;
  lsu_align u_align (
    .word_i(mem_rd_data), .off_i(addr_q[2:0]), .funct3_i(f3_q), .wdata_i(wdata_q),
    .ld_data_o(ld_data), .st_word_o(st_word)
  );
  always_comb begin
    bad = (req_is_store ? req_funct3[2] : req_funct3 == 3'b111) |
          misaligned(req_addr[2:0], req_funct3) |
          ((req_addr >> 3) >= XLEN'(DMEM_WORDS));
    active      = state_q == S_RD || state_q == S_CAP || state_q == S_WR;
    req_ready   = state_q == S_IDLE;
    resp_valid  = state_q == S_RESP;
    mem_rd      = state_q == S_RD;
    mem_wr      = state_q == S_WR;
    mem_addr    = active ? addr_q >> 3 : '0;
    mem_wr_data = mem_wr ? st_word : '0;
    resp_rdata  = rdata_q;
    resp_err    = err_q;
  end
  // Response registers change only on entry to RESP so they hold between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          f3_q    <= req_funct3;
          st_q    <= req_is_store;
          state_q <= bad ? S_RESP : (req_is_store && is_dword(req_funct3)) ? S_WR : S_RD;
          if (bad) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        S_RD:    state_q <= st_q ? S_WR : S_CAP;
        S_CAP: begin
          rdata_q <= ld_data;
          err_q   <= 1'b0;
          state_q <= S_RESP;
        end
        S_WR: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`ifdef LSU_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (state_q == S_RESP) begin
      if (err_q && stat_errs != '1) stat_errs <= stat_errs + 32'd1;
      if (!err_q && st_q && stat_stores != '1) stat_stores <= stat_stores + 32'd1;
      if (!err_q && !st_q && stat_loads != '1) stat_loads <= stat_loads + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus reset and back-to-back sequences against a memory model.
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err, mem_rd, mem_wr;
  logic [63:0] resp_rdata, mem_addr, mem_wr_data, mem_rd_data = '0;
  logic [63:0] mem [32] = '{default: 64'h0};
  logic [63:0] last_addr = '0;
  int rd_cnt = 0, wr_cnt = 0, checks = 0, errors = 0;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin mem_rd_data <= mem[mem_addr[4:0]]; rd_cnt++; end
    if (mem_wr) begin mem[mem_addr[4:0]] <= mem_wr_data; wr_cnt++; end
    if (mem_rd || mem_wr) last_addr <= mem_addr;
  end

  always @(negedge clk) begin
    if (mem_rd && mem_wr) begin
      checks++; errors++;
      $display("FAIL strobe_overlap: mem_rd=%b mem_wr=%b required not both high", mem_rd, mem_wr);
    end
  end

  typedef struct {
    logic st; logic [2:0] f3; logic [63:0] addr, wdata, rdata; logic err; int lat, nrd, nwr;
  } vec_t;

  function automatic vec_t mk(logic st, logic [2:0] f3, logic [63:0] addr, logic [63:0] wdata,
                              logic [63:0] rdata, logic err, int lat, int nrd, int nwr);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.err = err; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_is_store = v.st; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
  endtask

  task automatic run(input vec_t v, input string id);
    int lat, r0, w0;
    @(negedge clk);
    chk({id, " ready"}, 64'(req_ready), 64'd1);
    drive(v);
    req_valid = 1'b1;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 8);
    chk({id, " latency"}, 64'(lat), 64'(v.lat));
    chk({id, " rdata"}, resp_rdata, v.rdata);
    chk({id, " err"}, 64'(resp_err), 64'(v.err));
    chk({id, " mem_rd count"}, 64'(rd_cnt - r0), 64'(v.nrd));
    chk({id, " mem_wr count"}, 64'(wr_cnt - w0), 64'(v.nwr));
    if (v.nrd + v.nwr > 0) chk({id, " mem_addr"}, last_addr, v.addr >> 3);
  endtask

  localparam int NV = 27;
  vec_t tbl [NV];
  vec_t bb [3];
  int acc_cyc [3], resp_cyc [3];
  logic [63:0] got [3];

  initial begin
    tbl[0]  = mk(1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0, 0, 2, 0, 1);
    tbl[1]  = mk(0, 3'b011, 64'h10, 64'h0, 64'h1122334455667788, 0, 3, 1, 0);
    tbl[2]  = mk(0, 3'b000, 64'h17, 64'h0, 64'h11, 0, 3, 1, 0);
    tbl[3]  = mk(1, 3'b000, 64'h17, 64'h80, 64'h0, 0, 3, 1, 1);
    tbl[4]  = mk(0, 3'b000, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 3, 1, 0);
    tbl[5]  = mk(0, 3'b100, 64'h17, 64'h0, 64'h80, 0, 3, 1, 0);
    tbl[6]  = mk(1, 3'b000, 64'h17, 64'hFFFFFF11, 64'h0, 0, 3, 1, 1);
    tbl[7]  = mk(1, 3'b001, 64'h12, 64'hABCD, 64'h0, 0, 3, 1, 1);
    tbl[8]  = mk(0, 3'b011, 64'h10, 64'h0, 64'h11223344ABCD7788, 0, 3, 1, 0);
    tbl[9]  = mk(0, 3'b001, 64'h12, 64'h0, 64'hFFFFFFFFFFFFABCD, 0, 3, 1, 0);
    tbl[10] = mk(0, 3'b101, 64'h12, 64'h0, 64'hABCD, 0, 3, 1, 0);
    tbl[11] = mk(0, 3'b010, 64'h14, 64'h0, 64'h11223344, 0, 3, 1, 0);
    tbl[12] = mk(0, 3'b010, 64'h10, 64'h0, 64'hFFFFFFFFABCD7788, 0, 3, 1, 0);
    tbl[13] = mk(0, 3'b110, 64'h10, 64'h0, 64'h00000000ABCD7788, 0, 3, 1, 0);
    tbl[14] = mk(1, 3'b010, 64'h18, 64'h87654321DEADBEEF, 64'h0, 0, 3, 1, 1);
    tbl[15] = mk(1, 3'b010, 64'h1C, 64'h12345678, 64'h0, 0, 3, 1, 1);
    tbl[16] = mk(0, 3'b011, 64'h18, 64'h0, 64'h12345678DEADBEEF, 0, 3, 1, 0);
    tbl[17] = mk(0, 3'b011, 64'hF8, 64'h0, 64'h0, 0, 3, 1, 0);
    tbl[18] = mk(1, 3'b000, 64'hFF, 64'hA5, 64'h0, 0, 3, 1, 1);
    tbl[19] = mk(0, 3'b000, 64'hFF, 64'h0, 64'hFFFFFFFFFFFFFFA5, 0, 3, 1, 0);
    tbl[20] = mk(1, 3'b011, 64'h20, 64'hCAFEF00D12345678, 64'h0, 0, 2, 0, 1);
    tbl[21] = mk(0, 3'b010, 64'h0A, 64'h0, 64'h0, 1, 1, 0, 0);
    tbl[22] = mk(0, 3'b011, 64'h100, 64'h0, 64'h0, 1, 1, 0, 0);
    tbl[23] = mk(0, 3'b111, 64'h0, 64'h0, 64'h0, 1, 1, 0, 0);
    tbl[24] = mk(1, 3'b100, 64'h0, 64'h5, 64'h0, 1, 1, 0, 0);
    tbl[25] = mk(1, 3'b001, 64'h11, 64'h5, 64'h0, 1, 1, 0, 0);
    tbl[26] = mk(0, 3'b000, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1, 1, 0, 0);

    #3;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_rdata", resp_rdata, 64'd0);
    chk("reset resp_err", 64'(resp_err), 64'd0);
    chk("reset strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
    chk("reset mem_addr", mem_addr, 64'd0);
    chk("reset mem_wr_data", mem_wr_data, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run(tbl[i], $sformatf("v%0d", i));

    begin : reset_mid_store
      int w0;
      @(negedge clk);
      drive(mk(1, 3'b010, 64'h20, 64'hDEADBEEF, 0, 0, 0, 0, 0));
      req_valid = 1'b1;
      w0 = wr_cnt;
      @(posedge clk); #1 req_valid = 1'b0;
      chk("rst_mid mem_rd in RD", 64'(mem_rd), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
      chk("rst_mid mem_addr", mem_addr, 64'd0);
      chk("rst_mid mem_wr_data", mem_wr_data, 64'd0);
      chk("rst_mid resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_mid req_ready", 64'(req_ready), 64'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk("rst_mid no write", 64'(wr_cnt - w0), 64'd0);
      run(mk(0, 3'b011, 64'h20, 0, 64'hCAFEF00D12345678, 0, 3, 1, 0), "rst_mid reload");
    end

    begin : back_to_back
      int na, nr;
      bb[0] = mk(0, 3'b011, 64'h10, 0, 0, 0, 0, 0, 0);
      bb[1] = mk(0, 3'b011, 64'h18, 0, 0, 0, 0, 0, 0);
      bb[2] = mk(1, 3'b011, 64'h28, 64'h0102030405060708, 0, 0, 0, 0, 0);
      na = 0; nr = 0;
      @(negedge clk);
      drive(bb[0]);
      req_valid = 1'b1;
      for (int cyc = 0; cyc < 40 && nr < 3; cyc++) begin
        if (cyc > 0) @(negedge clk);
        if (resp_valid) begin got[nr] = resp_rdata; resp_cyc[nr] = cyc; nr++; end
        if (req_valid && req_ready) begin
          acc_cyc[na] = cyc; na++;
          @(posedge clk); #1;
          if (na < 3) drive(bb[na]); else req_valid = 1'b0;
        end
      end
      req_valid = 1'b0;
      chk("b2b responses", 64'(nr), 64'd3);
      chk("b2b accepts", 64'(na), 64'd3);
      if (nr == 3 && na == 3) begin
        chk("b2b rdata0", got[0], 64'h11223344ABCD7788);
        chk("b2b rdata1", got[1], 64'h12345678DEADBEEF);
        chk("b2b rdata2", got[2], 64'h0);
        chk("b2b lat0", 64'(resp_cyc[0] - acc_cyc[0]), 64'd3);
        chk("b2b accept1", 64'(acc_cyc[1] - resp_cyc[0]), 64'd1);
        chk("b2b accept2", 64'(acc_cyc[2] - resp_cyc[1]), 64'd1);
        chk("b2b lat2", 64'(resp_cyc[2] - acc_cyc[2]), 64'd2);
      end
      run(mk(0, 3'b011, 64'h28, 0, 64'h0102030405060708, 0, 3, 1, 0), "b2b readback");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
